// File: rtl/fpdivsqrt_req_arbiter.sv
// Round-robin sharing of one fdiv/fsqrt unit; grant->start 1 cycle, finish->response 1 cycle, one op in flight.
// Requesters are held off (req_ready low) until the previous response is accepted; unit start/finish are valid-ready.
module fpdivsqrt_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*3-1:0]  req_fp_format_i,
    input  logic [NUM_REQ-1:0]    req_is_fdiv_i,
    input  logic [NUM_REQ*64-1:0] req_opa_i,
    input  logic [NUM_REQ*64-1:0] req_opb_i,
    input  logic [NUM_REQ*3-1:0]  req_rm_i,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    input  logic [NUM_REQ-1:0]    rsp_ready_i,
    output logic [63:0]           rsp_res_o,
    output logic [4:0]            rsp_fflags_o,
    input  logic                  flush_i,
    output logic                  div_start_valid_o,
    input  logic                  div_start_ready_i,
    output logic [2:0]            div_fp_format_o,
    output logic                  div_is_fdiv_o,
    output logic [63:0]           div_opa_o,
    output logic [63:0]           div_opb_o,
    output logic [2:0]            div_rm_o,
    input  logic                  div_finish_valid_i,
    output logic                  div_finish_ready_o,
    input  logic [63:0]           div_res_i,
    input  logic [4:0]            div_fflags_i,
    output logic                  div_flush_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] owner_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] grant_idx;
    logic            grant_any;
    logic            grant;
    logic            load_res;
    logic            rr_adv;
    logic [63:0]     res_q;
    logic [4:0]      fflags_q;

    logic [2:0]      sel_fmt;
    logic            sel_fdiv;
    logic [63:0]     sel_opa;
    logic [63:0]     sel_opb;
    logic [2:0]      sel_rm;

    function automatic logic [ID_W-1:0] ptr_add(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return sum[ID_W-1:0];
    endfunction

    // Scan from the highest offset down so the requester nearest rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[ptr_add(rr_ptr_q, k)]) begin
                grant_any = 1'b1;
                grant_idx = ptr_add(rr_ptr_q, k);
            end
        end
    end

    assign grant       = (state_q == S_IDLE) && grant_any && !flush_i;
    assign req_ready_o = grant ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        sel_fmt  = '0;
        sel_fdiv = 1'b0;
        sel_opa  = '0;
        sel_opb  = '0;
        sel_rm   = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_idx == ID_W'(r)) begin
                sel_fmt  = req_fp_format_i[r*3 +: 3];
                sel_fdiv = req_is_fdiv_i[r];
                sel_opa  = req_opa_i[r*64 +: 64];
                sel_opb  = req_opb_i[r*64 +: 64];
                sel_rm   = req_rm_i[r*3 +: 3];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        load_res = 1'b0;
        rr_adv   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (div_start_ready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (div_finish_valid_i) begin
                    state_d  = S_RESP;
                    load_res = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i[owner_q]) begin
                    state_d = S_IDLE;
                    rr_adv  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // An abort wins over any handshake completing in the same cycle.
        if (flush_i && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            load_res = 1'b0;
            rr_adv   = 1'b1;
        end
    end

    assign busy_o             = (state_q != S_IDLE);
    assign div_start_valid_o  = (state_q == S_ISSUE);
    assign div_finish_ready_o = (state_q == S_WAIT);
    assign div_flush_o        = flush_i && (state_q != S_IDLE);
    assign rsp_valid_o        = ((state_q == S_RESP) && !flush_i) ? (NUM_REQ'(1) << owner_q) : '0;
    assign rsp_res_o          = res_q;
    assign rsp_fflags_o       = fflags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) owner_q <= grant_idx;
            if (rr_adv) rr_ptr_q <= ptr_add(owner_q, 1);
        end
    end

    // Operands are captured only at grant so the unit sees them stable across the start handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_fp_format_o <= '0;
            div_is_fdiv_o   <= 1'b0;
            div_opa_o       <= '0;
            div_opb_o       <= '0;
            div_rm_o        <= '0;
        end else if (grant) begin
            div_fp_format_o <= sel_fmt;
            div_is_fdiv_o   <= sel_fdiv;
            div_opa_o       <= sel_opa;
            div_opb_o       <= sel_opb;
            div_rm_o        <= sel_rm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q    <= '0;
            fflags_q <= '0;
        end else if (load_res) begin
            res_q    <= div_res_i;
            fflags_q <= div_fflags_i;
        end
    end

endmodule
